// File: rtl/booth_arb_pkg.sv
// Shared constants for the Booth multiplier arbiter: FSM encoding and default widths.
package booth_arb_pkg;

  localparam int unsigned STATE_W = 2;

  localparam logic [STATE_W-1:0] S_IDLE  = 2'd0;
  localparam logic [STATE_W-1:0] S_ISSUE = 2'd1;
  localparam logic [STATE_W-1:0] S_WAIT  = 2'd2;
  localparam logic [STATE_W-1:0] S_RESP  = 2'd3;

  localparam int unsigned DEF_NUM_REQ        = 4;
  localparam int unsigned DEF_OP_W           = 8;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 64;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority pick: first asserted req at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N    = 4,
  parameter int unsigned ID_W = 2
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic [N-1:0]    grant_c,
  output logic [ID_W-1:0] idx_c,
  output logic            any_c
);

  logic [ID_W-1:0] pos;

  always_comb begin
    grant_c = '0;
    idx_c   = '0;
    any_c   = 1'b0;
    pos     = '0;
    for (int unsigned k = 0; k < N; k++) begin
      pos = ID_W'((32'(ptr) + k) % N);
      if (!any_c && req[pos]) begin
        any_c        = 1'b1;
        grant_c[pos] = 1'b1;
        idx_c        = pos;
      end
    end
  end

endmodule

// File: rtl/booth_mul_arbiter.sv
// Round-robin front end sharing one sequential Booth multiplier among NUM_REQ clients.
// Optional WAIT-state watchdog enabled by defining BOOTH_ARB_TIMEOUT_EN.
module booth_mul_arbiter
  import booth_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ        = DEF_NUM_REQ,
  parameter int unsigned OP_W           = DEF_OP_W,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  localparam int unsigned ID_W   = $clog2(NUM_REQ),
  localparam int unsigned PROD_W = 2 * OP_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [NUM_REQ*OP_W-1:0] req_a,
  input  logic [NUM_REQ*OP_W-1:0] req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [PROD_W-1:0]       rsp_product,
  output logic                    rsp_err,
  output logic                    busy,
  output logic                    mul_go,
  output logic                    mul_rst,
  output logic [OP_W-1:0]         mul_mpcand,
  output logic [OP_W-1:0]         mul_mplier,
  input  logic                    mul_done,
  input  logic [PROD_W-1:0]       mul_product
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || OP_W == 0 || TIMEOUT_CYCLES == 0) begin : g_bad_params
    $error("booth_mul_arbiter: illegal parameter combination");
  end

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_next;
  logic [ID_W-1:0]    rr_ptr;
  logic [NUM_REQ-1:0] grant_c;
  logic [ID_W-1:0]    grant_idx_c;
  logic               grant_any_c;
  logic               accept_c;
  logic               timeout_c;

  rr_arbiter #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_rr (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .grant_c (grant_c),
    .idx_c   (grant_idx_c),
    .any_c   (grant_any_c)
  );

  // Only IDLE may accept; the grant is the handshake since valid is already set.
  assign accept_c  = (state == S_IDLE) && grant_any_c && !rst;
  assign req_ready = accept_c ? grant_c : '0;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (accept_c) state_next = S_ISSUE;
      S_ISSUE: state_next = S_WAIT;
      S_WAIT:  if (mul_done || timeout_c) state_next = S_RESP;
      S_RESP:  if (rsp_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      busy        <= 1'b0;
      mul_go      <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_product <= '0;
      mul_mpcand  <= '0;
      mul_mplier  <= '0;
    end else begin
      state     <= state_next;
      busy      <= (state_next != S_IDLE);
      mul_go    <= (state_next == S_ISSUE);
      rsp_valid <= (state_next == S_RESP);
      if (accept_c) begin
        mul_mpcand <= req_a[32'(grant_idx_c) * OP_W +: OP_W];
        mul_mplier <= req_b[32'(grant_idx_c) * OP_W +: OP_W];
        rsp_id     <= grant_idx_c;
      end
      // A done pulse beats a simultaneous watchdog expiry.
      if (state == S_WAIT) begin
        if (mul_done) begin
          rsp_product <= mul_product;
        end else if (timeout_c) begin
          rsp_product <= '0;
        end
      end
      if (state == S_RESP && rsp_ready) begin
        rr_ptr <= (rsp_id == ID_W'(NUM_REQ - 1)) ? '0 : rsp_id + ID_W'(1);
      end
    end
  end

`ifdef BOOTH_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wd_cnt;
  logic             abort;

  assign timeout_c = (state == S_WAIT) && (wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
  assign mul_rst   = rst | abort;

  // Watchdog: counts WAIT cycles and pulses a multiplier reset on expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt  <= '0;
      abort   <= 1'b0;
      rsp_err <= 1'b0;
    end else begin
      abort <= timeout_c && !mul_done;
      if (state == S_ISSUE) begin
        wd_cnt <= '0;
      end else if (state == S_WAIT) begin
        wd_cnt <= wd_cnt + CNT_W'(1);
      end
      if (state == S_WAIT) begin
        if (mul_done) begin
          rsp_err <= 1'b0;
        end else if (timeout_c) begin
          rsp_err <= 1'b1;
        end
      end
    end
  end
`else
  assign timeout_c = 1'b0;
  assign mul_rst   = rst;
  assign rsp_err   = 1'b0;
`endif

endmodule
